// File: rtl/branch_predict_resolve_unit_pkg.sv
// Shared types for the branch predict/resolve slice: branch control encoding,
// predictor entry layout and the 2-bit saturating counter helpers.
package package_project_typedefs;

  typedef enum logic [3:0] {
    NO_JUMP_BRANCH = 4'd0,
    BRANCH_EQ      = 4'd1,
    BRANCH_NE      = 4'd2,
    BRANCH_LT      = 4'd3,
    BRANCH_GE      = 4'd4,
    BRANCH_LTU     = 4'd5,
    BRANCH_GEU     = 4'd6,
    JUMP_AL        = 4'd7,
    JUMP_ALR       = 4'd8
  } BranchControl;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Entry layout for the default 32-bit datapath with 8-bit tags.
  localparam int PRED_XLEN  = 32;
  localparam int PRED_TAG_W = 8;

  typedef struct packed {
    logic                  valid;
    logic [PRED_TAG_W-1:0] tag;
    logic [PRED_XLEN-1:0]  target;
    logic [1:0]            ctr;
    logic                  is_jump;
  } pred_entry_t;

  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && (ctr != CTR_ST)) begin
      nxt = ctr + 2'd1;
    end else if (!taken && (ctr != CTR_SNT)) begin
      nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predict_resolve_unit_compare.sv
// branch_compare_unit: combinational branch condition and target computation
// for the execute stage, XLEN-wide with wrap-around arithmetic.
module branch_compare_unit
  import package_project_typedefs::*;
#(
  parameter int XLEN = 32
) (
  input  logic         valid,
  input  BranchControl branch_type,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] imm,
  output logic            taken,
  output logic [XLEN-1:0] target
);

  logic            cond;
  logic [XLEN-1:0] jalr_sum;

  always_comb begin
    cond = 1'b0;
    case (branch_type)
      BRANCH_EQ:          cond = (rs1 == rs2);
      BRANCH_NE:          cond = (rs1 != rs2);
      BRANCH_LT:          cond = ($signed(rs1) <  $signed(rs2));
      BRANCH_GE:          cond = ($signed(rs1) >= $signed(rs2));
      BRANCH_LTU:         cond = (rs1 <  rs2);
      BRANCH_GEU:         cond = (rs1 >= rs2);
      JUMP_AL, JUMP_ALR:  cond = 1'b1;
      default:            cond = 1'b0;
    endcase
  end

  assign taken = valid & cond;

  // JALR targets are register-relative with bit 0 forced low.
  assign jalr_sum = rs1 + imm;
  assign target   = (branch_type == JUMP_ALR) ? (jalr_sum & ~XLEN'(1)) : (pc + imm);

endmodule

// File: rtl/branch_predict_resolve_unit.sv
// Execute-stage branch resolution plus a bimodal predictor with tagged targets.
// Optional BRANCH_PRED_PERF_EN adds saturating branch/mispredict counters.
module branch_predict_resolve_unit
  import package_project_typedefs::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] f_pc,
  output logic            f_pred_taken,
  output logic [XLEN-1:0] f_pred_target,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  BranchControl    ex_branch_type,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic [XLEN-1:0] ex_imm,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            branch_decision,
  output logic [XLEN-1:0] branch_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc
`ifdef BRANCH_PRED_PERF_EN
  ,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_LO = IDX_W + 2;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    logic [1:0]       ctr;
    logic             is_jump;
  } entry_t;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic             jump_q   [ENTRIES];

  logic [IDX_W-1:0] f_idx, ex_idx;
  logic [TAG_W-1:0] f_tag, ex_tag;
  entry_t           f_entry;
  logic             f_hit;

  logic             ex_qual, ex_is_jump, ex_hit;
  logic             mis_next;
  logic [XLEN-1:0]  redirect_next;
  logic             wr_en, wr_tgt_en, wr_jump;
  logic [1:0]       wr_ctr;

  assign f_idx  = f_pc[IDX_W+1:2];
  assign f_tag  = f_pc[TAG_LO+TAG_W-1:TAG_LO];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[TAG_LO+TAG_W-1:TAG_LO];

  // Lookup reads the registered table only, so a same-cycle update is not visible.
  assign f_entry       = '{valid_q[f_idx], tag_q[f_idx], target_q[f_idx], ctr_q[f_idx], jump_q[f_idx]};
  assign f_hit         = f_entry.valid && (f_entry.tag == f_tag);
  assign f_pred_taken  = f_hit && (f_entry.is_jump || f_entry.ctr[1]);
  assign f_pred_target = f_pred_taken ? f_entry.target : (f_pc + XLEN'(4));

  branch_compare_unit #(
    .XLEN(XLEN)
  ) u_compare (
    .valid       (ex_valid),
    .branch_type (ex_branch_type),
    .pc          (ex_pc),
    .rs1         (ex_rs1),
    .rs2         (ex_rs2),
    .imm         (ex_imm),
    .taken       (branch_decision),
    .target      (branch_target)
  );

  assign ex_qual    = ex_valid && (ex_branch_type != NO_JUMP_BRANCH);
  assign ex_is_jump = (ex_branch_type == JUMP_AL) || (ex_branch_type == JUMP_ALR);
  assign ex_hit     = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  assign mis_next = (branch_decision != ex_pred_taken) ||
                    (branch_decision && ex_pred_taken && (branch_target != ex_pred_target));
  assign redirect_next = branch_decision ? branch_target : (ex_pc + XLEN'(4));

  // Jumps always (re)write as strongly taken; branches train on hit, allocate on taken miss.
  always_comb begin
    wr_en     = 1'b0;
    wr_tgt_en = 1'b0;
    wr_jump   = 1'b0;
    wr_ctr    = ctr_q[ex_idx];
    if (ex_qual) begin
      if (ex_is_jump) begin
        wr_en     = 1'b1;
        wr_tgt_en = 1'b1;
        wr_jump   = 1'b1;
        wr_ctr    = CTR_ST;
      end else if (ex_hit) begin
        wr_en     = 1'b1;
        wr_tgt_en = branch_decision;
        wr_ctr    = ctr_step(ctr_q[ex_idx], branch_decision);
      end else if (branch_decision) begin
        wr_en     = 1'b1;
        wr_tgt_en = 1'b1;
        wr_ctr    = CTR_WT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
        jump_q[i]  <= 1'b0;
      end
    end else if (wr_en) begin
      valid_q[ex_idx] <= 1'b1;
      ctr_q[ex_idx]   <= wr_ctr;
      jump_q[ex_idx]  <= wr_jump;
    end
  end

  // Tags and targets are meaningless while valid is clear, so they need no reset.
  always_ff @(posedge clk) begin
    if (wr_tgt_en) begin
      tag_q[ex_idx]    <= ex_tag;
      target_q[ex_idx] <= branch_target;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      mispredict <= ex_qual && mis_next;
      if (ex_qual && mis_next) begin
        redirect_pc <= redirect_next;
      end
    end
  end

`ifdef BRANCH_PRED_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (ex_qual && (perf_branches != '1)) begin
        perf_branches <= perf_branches + 32'd1;
      end
      if (ex_qual && mis_next && (perf_mispredicts != '1)) begin
        perf_mispredicts <= perf_mispredicts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_predict_resolve_unit.sv
// Scoreboard bench for branch_predict_resolve_unit: directed cases then random
// traffic, checked against a table-level behavioural predictor model.
module tb_branch_predict_resolve_unit;
  import package_project_typedefs::*;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [31:0]  f_pc;
  logic         f_pred_taken;
  logic [31:0]  f_pred_target;
  logic         ex_valid;
  logic [31:0]  ex_pc;
  BranchControl ex_branch_type;
  logic [31:0]  ex_rs1, ex_rs2, ex_imm;
  logic         ex_pred_taken;
  logic [31:0]  ex_pred_target;
  logic         branch_decision;
  logic [31:0]  branch_target;
  logic         mispredict;
  logic [31:0]  redirect_pc;

  always #5 clk = ~clk;

  branch_predict_resolve_unit #(
    .XLEN(32), .ENTRIES(64), .TAG_W(8)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .f_pc           (f_pc),
    .f_pred_taken   (f_pred_taken),
    .f_pred_target  (f_pred_target),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_branch_type (ex_branch_type),
    .ex_rs1         (ex_rs1),
    .ex_rs2         (ex_rs2),
    .ex_imm         (ex_imm),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .branch_decision(branch_decision),
    .branch_target  (branch_target),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc)
  );

  typedef struct {
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        decision;
    logic [31:0] target;
    bit          check_target;
    logic        mis;
    logic [31:0] redirect;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   cycle  = 0;

  // Reference predictor: 64 entries indexed by pc[7:2], tagged by pc[15:8].
  bit          m_valid [64];
  logic [7:0]  m_tag   [64];
  logic [31:0] m_tgt   [64];
  int          m_ctr   [64];
  bit          m_jump  [64];
  bit          m_mis;
  logic [31:0] m_redir;

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
      m_jump[i]  = 1'b0;
      m_tag[i]   = '0;
      m_tgt[i]   = '0;
    end
    m_mis   = 1'b0;
    m_redir = '0;
  endtask

  function automatic logic [32:0] model_lookup(input logic [31:0] pc);
    int i;
    bit tk;
    i  = int'(pc[7:2]);
    tk = m_valid[i] && (m_tag[i] == pc[15:8]) && (m_jump[i] || (m_ctr[i] >= 2));
    return {tk, tk ? m_tgt[i] : pc + 32'd4};
  endfunction

  function automatic bit res_taken(input BranchControl t, input logic [31:0] a, input logic [31:0] b);
    case (t)
      BRANCH_EQ:  return a == b;
      BRANCH_NE:  return a != b;
      BRANCH_LT:  return $signed(a) <  $signed(b);
      BRANCH_GE:  return $signed(a) >= $signed(b);
      BRANCH_LTU: return a <  b;
      BRANCH_GEU: return a >= b;
      JUMP_AL, JUMP_ALR: return 1'b1;
      default:    return 1'b0;
    endcase
  endfunction

  // Drive one cycle, queue what the DUT must show this cycle, then advance the model past the edge.
  task automatic applyStimulus(input logic [31:0] fpc, input logic v, input BranchControl t,
                               input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [31:0] imm, input logic pt, input logic [31:0] ptgt,
                               input bit drop);
    exp_t        e;
    logic [32:0] lk;
    bit          tk, qual, mis, hit;
    logic [31:0] tg;
    int          ei;
    @(posedge clk);
    #1;
    f_pc = fpc; ex_valid = v; ex_branch_type = t; ex_pc = pc;
    ex_rs1 = rs1; ex_rs2 = rs2; ex_imm = imm; ex_pred_taken = pt; ex_pred_target = ptgt;

    lk = model_lookup(fpc);
    tk = v && res_taken(t, rs1, rs2);
    tg = (t == JUMP_ALR) ? ((rs1 + imm) & ~32'd1) : (pc + imm);
    e.pred_taken   = lk[32];
    e.pred_target  = lk[31:0];
    e.decision     = tk;
    e.target       = tg;
    e.check_target = (t != NO_JUMP_BRANCH);
    e.mis          = m_mis;
    e.redirect     = m_redir;
    e.cyc          = cycle;
    cycle++;
    exp_q.push_back(e);

    if (drop) begin
      model_reset();
    end else begin
      qual  = v && (t != NO_JUMP_BRANCH);
      m_mis = 1'b0;
      if (qual) begin
        mis   = (tk != pt) || (tk && pt && (tg != ptgt));
        m_mis = mis;
        if (mis) m_redir = tk ? tg : pc + 32'd4;
        ei  = int'(pc[7:2]);
        hit = m_valid[ei] && (m_tag[ei] == pc[15:8]);
        if ((t == JUMP_AL) || (t == JUMP_ALR)) begin
          m_valid[ei] = 1'b1; m_tag[ei] = pc[15:8]; m_tgt[ei] = tg; m_ctr[ei] = 3; m_jump[ei] = 1'b1;
        end else if (hit) begin
          if (tk) begin
            m_ctr[ei] = (m_ctr[ei] == 3) ? 3 : m_ctr[ei] + 1;
            m_tgt[ei] = tg;
          end else begin
            m_ctr[ei] = (m_ctr[ei] == 0) ? 0 : m_ctr[ei] - 1;
          end
          m_jump[ei] = 1'b0;
        end else if (tk) begin
          m_valid[ei] = 1'b1; m_tag[ei] = pc[15:8]; m_tgt[ei] = tg; m_ctr[ei] = 2; m_jump[ei] = 1'b0;
        end
      end
    end
  endtask

  task automatic idle(input logic [31:0] fpc);
    applyStimulus(fpc, 1'b0, NO_JUMP_BRANCH, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  // Resolution is driven, then reset is pulled before the edge that would commit it.
  task automatic resetMidUpdate(input logic [31:0] pc, input logic [31:0] imm);
    applyStimulus(pc, 1'b1, BRANCH_EQ, pc, 32'd9, 32'd9, imm, 1'b0, 32'h0, 1'b1);
    #5 reset_n = 1'b0;
    @(posedge clk);
    #1 ex_valid = 1'b0;
    #2 reset_n = 1'b1;
  endtask

  task automatic compare(input string name, input int cyc, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passed++;
    else $display("[TB] FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, want);
  endtask

  task automatic checkOutput(input exp_t e);
    compare("f_pred_taken", e.cyc, {31'b0, f_pred_taken}, {31'b0, e.pred_taken});
    compare("f_pred_target", e.cyc, f_pred_target, e.pred_target);
    compare("branch_decision", e.cyc, {31'b0, branch_decision}, {31'b0, e.decision});
    if (e.check_target) compare("branch_target", e.cyc, branch_target, e.target);
    compare("mispredict", e.cyc, {31'b0, mispredict}, {31'b0, e.mis});
    compare("redirect_pc", e.cyc, redirect_pc, e.redirect);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  function automatic logic [31:0] rand_pc(input bit jump);
    logic [7:0]  tag;
    logic [5:0]  idx;
    logic [15:0] hi;
    tag = jump ? (8'h80 | 8'($urandom_range(1, 2))) : 8'($urandom_range(1, 3));
    idx = 6'($urandom_range(0, 7));
    hi  = 16'($urandom_range(0, 1));
    return {hi, tag, idx, 2'b00};
  endfunction

  initial begin : driver
    logic [31:0] ops [8];
    reset_n = 1'b0;
    f_pc = '0; ex_valid = 1'b0; ex_branch_type = NO_JUMP_BRANCH; ex_pc = '0;
    ex_rs1 = '0; ex_rs2 = '0; ex_imm = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    idle(32'h100);
    applyStimulus(32'h100, 1'b1, BRANCH_EQ, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0, 32'h0, 1'b0);
    idle(32'h100);
    applyStimulus(32'h104, 1'b1, BRANCH_LT,  32'h104, -32'sd6, 32'd5, 32'h40, 1'b0, 32'h0, 1'b0);
    applyStimulus(32'h108, 1'b1, BRANCH_LTU, 32'h108, -32'sd6, 32'd5, 32'h40, 1'b0, 32'h0, 1'b0);
    applyStimulus(32'h10c, 1'b1, BRANCH_GEU, 32'h10c, 32'd5, -32'sd6, 32'h40, 1'b0, 32'h0, 1'b0);
    idle(32'h104);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(32'h100, 1'b1, BRANCH_EQ, 32'h100, 32'd1, 32'd2, 32'h20, 1'b0, 32'h0, 1'b0);
      idle(32'h100);
    end
    applyStimulus(32'h100, 1'b1, BRANCH_EQ, 32'h100, 32'd3, 32'd3, 32'h20, 1'b0, 32'h0, 1'b0);
    idle(32'h100);
    applyStimulus(32'h8000, 1'b1, JUMP_ALR, 32'h8000, 32'd5, 32'd0, 32'd20, 1'b1, 32'h18, 1'b0);
    idle(32'h8000);
    applyStimulus(32'h200, 1'b1, BRANCH_EQ, 32'h200, 32'd7, 32'd7, 32'h10, 1'b0, 32'h0, 1'b0);
    idle(32'h200);
    resetMidUpdate(32'h300, 32'h44);
    idle(32'h300);

    for (int n = 0; n < 400; n++) begin
      BranchControl t;
      logic [31:0]  pc, fpc, rs1, rs2, imm, ptgt;
      logic [32:0]  lk;
      logic         pt, v;
      ops[0] = 32'd0; ops[1] = 32'd5; ops[2] = -32'sd6; ops[3] = 32'hffff_ffff;
      ops[4] = 32'h7fff_ffff; ops[5] = 32'h8000_0000; ops[6] = $urandom; ops[7] = 32'd5;
      t   = BranchControl'(4'($urandom_range(0, 8)));
      pc  = rand_pc((t == JUMP_AL) || (t == JUMP_ALR));
      rs1 = ops[$urandom_range(0, 7)];
      rs2 = ops[$urandom_range(0, 7)];
      imm = 32'($urandom_range(0, 255)) - 32'd128;
      v   = ($urandom_range(0, 9) != 0);
      fpc = ($urandom_range(0, 1) == 1) ? pc : rand_pc($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) != 0) begin
        lk   = model_lookup(pc);
        pt   = lk[32];
        ptgt = lk[31:0];
      end else begin
        pt   = 1'($urandom_range(0, 1));
        ptgt = ($urandom_range(0, 1) == 1) ? pc + imm : $urandom;
      end
      if ((n % 97) == 50) resetMidUpdate(pc, imm);
      else applyStimulus(fpc, v, t, pc, rs1, rs2, imm, pt, ptgt, 1'b0);
    end

    idle(32'h0);
    repeat (2) @(posedge clk);
    #1;
    compare("scoreboard_drained", cycle, 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/branch_predict_resolve_unit.md
Name: branch_predict_resolve_unit

Overview:
- Parametrised successor to the execute-stage branch decision logic.
- Resolves conditional branches and jumps in execute, with XLEN-wide data.
- Adds a bimodal branch predictor with a tagged target buffer: combinational lookup for fetch, registered update from execute.
- Produces a registered mispredict/redirect pulse one cycle after resolution, for front-end flush.

Parameters:
- XLEN, 32, datapath and PC width.
- ENTRIES, 64, predictor table depth; power of two, at least 2. IDX_W = log2(ENTRIES).
- TAG_W, 8, tag bits per entry. Requires IDX_W+2+TAG_W <= XLEN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- f_pc  in  XLEN  fetch PC for lookup.
- f_pred_taken  out  1  predicted taken.
- f_pred_target  out  XLEN  predicted next PC.
- ex_valid  in  1  execute slot holds a live instruction.
- ex_pc  in  XLEN  PC of the execute instruction.
- ex_branch_type  in  BranchControl  NO_JUMP_BRANCH, BRANCH_EQ/NE/LT/GE/LTU/GEU, JUMP_AL, JUMP_ALR.
- ex_rs1, ex_rs2, ex_imm  in  XLEN  operands and sign-extended immediate.
- ex_pred_taken  in  1  prediction carried from fetch.
- ex_pred_target  in  XLEN  predicted PC carried from fetch.
- branch_decision  out  1  combinational actual-taken.
- branch_target  out  XLEN  combinational actual target.
- mispredict  out  1  registered one-cycle pulse.
- redirect_pc  out  XLEN  registered correct next PC; valid while mispredict=1.

Behaviour:
- Index = pc[IDX_W+1:2]. Tag = pc[IDX_W+2+TAG_W-1:IDX_W+2].
- Entry fields: valid, tag, target (XLEN), 2-bit counter, is_jump.

Lookup (combinational from state):
- hit = valid & tag match.
- f_pred_taken = hit & (is_jump | ctr[1]).
- f_pred_target = stored target if f_pred_taken, else f_pc+4 (mod 2^XLEN).

Resolve (combinational):
- EQ/NE: equality. LT/GE: signed compare. LTU/GEU: unsigned compare.
- JUMP_AL, JUMP_ALR: always taken. NO_JUMP_BRANCH: not taken.
- branch_decision = 0 when ex_valid=0.
- branch_target = ex_pc+ex_imm for branches and JAL; (ex_rs1+ex_imm) with bit0 cleared for JALR. Wrap-around arithmetic.

Mispredict (registered):
- Evaluated only for ex_valid=1 and type != NO_JUMP_BRANCH.
- Mispredict when actual != ex_pred_taken, or both taken and branch_target != ex_pred_target.
- Next edge: mispredict <= that result; redirect_pc <= taken ? branch_target : ex_pc+4.
- redirect_pc holds its last value when mispredict=0.

Update (same edge, same qualifier):
- Hit: ctr saturating +1 if taken, -1 if not (00 and 11 stick). Target written when taken.
- Miss and taken: allocate with valid=1, tag, target, ctr=10 (weakly taken).
- Miss and not taken: no write.
- Jumps: is_jump=1, ctr=11.

Boundary conditions:
- Lookup and update to the same index in one cycle: lookup sees pre-update contents (no bypass).
- Aliasing index with a different tag: replaced on allocate only.
- Reset: asynchronous. Clears all valid bits, counters to 01, is_jump=0, mispredict=0, redirect_pc=0. A resolution in flight at reset is dropped.

Optional Feature:
BRANCH_PRED_PERF_EN:
- Defined: adds outputs perf_branches and perf_mispredicts (32 bits each).
- perf_branches increments on every qualified resolution; perf_mispredicts on every mispredict.
- Both saturate at all-ones and are cleared by reset.
- Undefined: these ports and counters do not exist; behaviour otherwise identical.

Decomposition:
- package_project_typedefs holds BranchControl, the pred_entry_t struct (valid/tag/target/ctr/is_jump), and counter constants CTR_SNT=00, CTR_WNT=01, CTR_WT=10, CTR_ST=11.
- One natural sub-module: branch_compare_unit, the combinational compare/target logic, parametrised on XLEN.

Test Plan:
- Reset, then f_pc=0x100 -> f_pred_taken=0, f_pred_target=0x104, mispredict=0.
- BRANCH_EQ, ex_pc=0x100, rs1=rs2=5, imm=0x20, pred_taken=0 -> branch_decision=1, target=0x120. Next cycle mispredict=1, redirect_pc=0x120. Then f_pc=0x100 -> pred_taken=1, target=0x120.
- BRANCH_LT rs1=-6, rs2=5 -> taken. BRANCH_LTU same operands -> not taken. BRANCH_GEU rs1=5, rs2=-6 -> not taken.
- Same branch resolved not-taken three times from ctr=10 -> counter reaches 00, lookup not taken. Fourth not-taken -> stays 00.
- JUMP_ALR rs1=5, imm=20, pred_target=0x18 -> target=0x18 (bit0 cleared), mispredict=0.
- Lookup and update to the same index in one cycle -> lookup returns old entry. Assert reset_n mid-update -> no entry written, mispredict=0.
